noc_vc_flit_arbiter: RTL



---
 rtl/noc_arb_pkg.sv | 20 ++
 rtl/noc_vc_flit_arbiter_rr_pick.sv | 25 ++
 rtl/noc_vc_flit_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types and width helpers for the NoC VC flit arbiter.
package noc_arb_pkg;

    // Arbiter control state: waiting for a head, or locked onto one VC.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Output flit word is {valid, payload}.
    function automatic int flit_width(input int data_width);
        return data_width + 1;
    endfunction

    // The valid flag sits in the MSB of the output flit word.
    function automatic int valid_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/noc_vc_flit_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo VC_NUM.
module rr_pick #(
    parameter int VC_NUM = 4,
    parameter int IDX_W  = $clog2(VC_NUM)
) (
    input  logic [VC_NUM-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Scan from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        idx = '0;
        any = |req;
        for (int off = VC_NUM - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % VC_NUM]) begin
                idx = IDX_W'((int'(ptr) + off) % VC_NUM);
            end
        end
    end

endmodule

// File: rtl/noc_vc_flit_arbiter.sv
// Wormhole round-robin arbiter sharing one NoC flit port among VC_NUM
// virtual channels. One VC is locked from head to tail; accepted flits go
// into a registered output stage that honours buffer_busy.
// Optional build macro: NOC_ARB_WATCHDOG_EN (lock watchdog, err_timeout port).
module noc_vc_flit_arbiter
    import noc_arb_pkg::*;
#(
    parameter int VC_NUM         = 4,
    parameter int DATA_WIDTH     = 128,
    parameter int VC_IDX_W       = $clog2(VC_NUM)
`ifdef NOC_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                                 noc_clk,
    input  logic                                 noc_rst,
    input  logic [VC_NUM-1:0]                    in_valid,
    input  logic [VC_NUM*DATA_WIDTH-1:0]         in_data,
    input  logic [VC_NUM-1:0]                    in_head,
    input  logic [VC_NUM-1:0]                    in_tail,
    output logic [VC_NUM-1:0]                    in_ready,
    output logic [flit_width(DATA_WIDTH)-1:0]    noc2axi_data,
    output logic                                 s_is_head,
    output logic                                 s_is_tail,
    input  logic                                 buffer_busy,
    output logic [VC_IDX_W-1:0]                  grant_vc,
    output logic                                 locked,
`ifdef NOC_ARB_WATCHDOG_EN
    output logic                                 err_timeout,
`endif
    output logic                                 err_proto
);

    localparam int VLD = valid_bit(DATA_WIDTH);

    arb_state_e            state_q, state_d;
    logic [VC_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [VC_IDX_W-1:0]   grant_q, grant_d;
    logic [VC_IDX_W-1:0]   pick_idx, next_ptr;
    logic                  pick_any;
    logic                  first_q, first_d;
    logic                  out_valid, out_load, accept;
    logic                  err_proto_d, timeout_hit;
    logic [VC_NUM-1:0]     head_req;
    logic [DATA_WIDTH-1:0] acc_data;

    assign out_valid = noc2axi_data[VLD];
    assign head_req  = in_valid & in_head;
    assign acc_data  = in_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr  = (grant_q == VC_IDX_W'(VC_NUM - 1)) ? '0 : grant_q + 1'b1;
    assign grant_vc  = grant_q;
    assign locked    = (state_q == LOCKED);

    rr_pick #(
        .VC_NUM (VC_NUM),
        .IDX_W  (VC_IDX_W)
    ) u_rr_pick (
        .req (head_req),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state, grant and handshake decode for the lock FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        first_d     = first_q;
        in_ready    = '0;
        out_load    = 1'b0;
        accept      = 1'b0;
        err_proto_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    first_d = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                out_load          = ~out_valid | ~buffer_busy;
                in_ready[grant_q] = out_load;
                accept            = out_load & in_valid[grant_q];
                if (accept) begin
                    first_d     = 1'b0;
                    // A second head inside a locked packet is a protocol error.
                    err_proto_d = in_head[grant_q] & ~first_q;
                    if (in_tail[grant_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (timeout_hit) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lock FSM state, round-robin pointer and granted VC.
    always_ff @(posedge noc_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (noc_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            first_q  <= first_d;
        end
    end

    // Output stage: load on accept, hold while stalled, clear once consumed.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            noc2axi_data <= '0;
            s_is_head    <= 1'b0;
            s_is_tail    <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            err_proto <= err_proto_d;
            if (accept) begin
                noc2axi_data <= {1'b1, acc_data};
                s_is_head    <= in_head[grant_q] & first_q;
                s_is_tail    <= in_tail[grant_q];
            end else if (out_valid && !buffer_busy) begin
                noc2axi_data <= '0;
                s_is_head    <= 1'b0;
                s_is_tail    <= 1'b0;
            end
        end
    end

`ifdef NOC_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_count;

    // Starved cycles only: locked, granted VC silent, output not stalled.
    assign wd_count    = (state_q == LOCKED) & ~in_valid[grant_q] & out_load;
    assign timeout_hit = wd_count & (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter and its one-cycle timeout pulse.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            wd_cnt_q    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (state_q != LOCKED || accept || timeout_hit) begin
                wd_cnt_q <= '0;
            end else if (wd_count) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
